// File: rtl/fetch_queue_unit_if.sv
// Fetch-side bus bundle for fetch_queue_unit.
// Carries two links: the request/response link to instruction memory
// (imem_*) and the instruction queue head link to decode (*_D).
// The master modport is the fetch unit. The slave modport is the
// memory/decode environment.
interface fetch_queue_unit_if #(
  parameter int N       = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req_F;
  logic [N-1:0]       imem_addr_F;
  logic               imem_ready_F;
  logic               imem_rvalid_F;
  logic [INSTR_W-1:0] imem_rdata_F;
  logic               valid_D;
  logic [INSTR_W-1:0] instr_D;
  logic [N-1:0]       pc_D;
  logic               ready_D;

  modport master (
    output imem_req_F, imem_addr_F, valid_D, instr_D, pc_D,
    input  imem_ready_F, imem_rvalid_F, imem_rdata_F, ready_D
  );

  modport slave (
    input  imem_req_F, imem_addr_F, valid_D, instr_D, pc_D,
    output imem_ready_F, imem_rvalid_F, imem_rdata_F, ready_D
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a DEPTH-entry instruction/PC queue.
// At most one memory request is outstanding at any time.
// Exception, ERET and branch redirects flush the queue. A redirect
// also squashes any in-flight response that is still outstanding.
// Optional build macro FETCH_PERF_CNT_EN adds two counters:
// fetched_cnt counts queue pushes, and squashed_cnt counts discarded
// work (dropped responses plus entries lost at each flush).

// Overflow checker: a push must never land on a full queue.
module fetch_queue_unit_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  property no_push_when_full_p;
    @(posedge clk) disable iff (!rst_n) push |-> (count != FULL_CNT);
  endproperty

  a_no_push_when_full: assert property (no_push_when_full_p);
endmodule

module fetch_queue_unit #(
  parameter int           N          = 64,
  parameter int           INSTR_W    = 32,
  parameter int           DEPTH      = 4,
  parameter logic [N-1:0] RESET_PC   = {N{1'b0}},
  parameter logic [N-1:0] EXC_VECTOR = N'(64'hD8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Exc_F,
  input  logic                ERet_F,
  input  logic [N-1:0]        ERetAddr_F,
  input  logic                PCSrc_F,
  input  logic [N-1:0]        PCBranch_F,
  fetch_queue_unit_if.master  fq
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetched_cnt,
  output logic [31:0]         squashed_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e               state_r;
  logic [N-1:0]         pc_r;
  logic [N-1:0]         inflight_pc_r;
  logic                 kill_r;

  logic [CNT_W-1:0]     count_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [INSTR_W-1:0]   instr_mem_r [DEPTH];
  logic [N-1:0]         pc_mem_r    [DEPTH];

  logic                 redirect_s;
  logic [N-1:0]         target_s;
  logic                 req_s;
  logic                 accept_s;
  logic                 rsp_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 not_empty_s;

  // Pointer advance; wraps naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

  // Redirect arbitration and the issue/response/queue handshake decode.
  always_comb begin
    redirect_s  = Exc_F | ERet_F | PCSrc_F;
    not_empty_s = (count_r != {CNT_W{1'b0}});

    if (Exc_F) begin
      target_s = EXC_VECTOR;
    end else if (ERet_F) begin
      target_s = ERetAddr_F;
    end else if (PCSrc_F) begin
      target_s = PCBranch_F;
    end else begin
      target_s = pc_r;
    end

    // A redirect cycle never issues, so the new target goes out cleanly next cycle.
    // The reset term keeps the request low while reset is asserted.
    if (reset && (state_r == ST_RUN) && (count_r < FULL_CNT) && !redirect_s) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end

    accept_s = req_s & fq.imem_ready_F;
    // Responses only mean something while a request is outstanding.
    rsp_s    = (state_r == ST_WAIT) & fq.imem_rvalid_F;
    // A killed response, or one that coincides with a redirect, is dropped.
    push_s   = rsp_s & ~kill_r & ~redirect_s;
    // Flush beats pop: a pop in a redirect cycle is discarded.
    pop_s    = not_empty_s & fq.ready_D & ~redirect_s;
  end

  assign fq.imem_req_F  = req_s;
  assign fq.imem_addr_F = pc_r;
  assign fq.valid_D     = not_empty_s;

  // Queue head presented to decode; zero while the queue is empty.
  always_comb begin
    if (not_empty_s) begin
      fq.instr_D = instr_mem_r[rd_ptr_r];
      fq.pc_D    = pc_mem_r[rd_ptr_r];
    end else begin
      fq.instr_D = {INSTR_W{1'b0}};
      fq.pc_D    = {N{1'b0}};
    end
  end

  // Fetch FSM: PC sequencing, outstanding-request tracking and squash flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      inflight_pc_r <= {N{1'b0}};
      kill_r        <= 1'b0;
    end else begin
      if (redirect_s) begin
        pc_r <= target_s;
      end else if (accept_s) begin
        pc_r <= pc_r + N'(4);
      end else begin
        pc_r <= pc_r;
      end

      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            state_r       <= ST_WAIT;
            inflight_pc_r <= pc_r;
            kill_r        <= 1'b0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_WAIT: begin
          if (fq.imem_rvalid_F) begin
            // Response retires the request whether it was kept or dropped.
            state_r <= ST_RUN;
            kill_r  <= 1'b0;
          end else if (redirect_s) begin
            // Still waiting: remember to drop the response when it shows up.
            state_r <= ST_WAIT;
            kill_r  <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_RUN;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (redirect_s) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage: the returned instruction is tagged with the PC that fetched it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= fq.imem_rdata_F;
      pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        drop_s;
  logic [31:0] flush_loss_s;

  // Squash accounting inputs: dropped response plus entries lost at a flush.
  always_comb begin
    drop_s = rsp_s & (kill_r | redirect_s);
    if (redirect_s) begin
      flush_loss_s = 32'(count_r);
    end else begin
      flush_loss_s = 32'd0;
    end
  end

  // Performance counters; both wrap at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_cnt  <= 32'd0;
      squashed_cnt <= 32'd0;
    end else begin
      if (push_s) begin
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      squashed_cnt <= squashed_cnt + {31'd0, drop_s} + flush_loss_s;
    end
  end
`endif

  fetch_queue_unit_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage for the exception-capable ARM core. Holds the PC and issues one request at a time to an instruction memory that uses a ready/valid handshake with variable latency. Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding decode. Redirects on exception, exception return (ERET) and branch, flushing the FIFO and squashing any stale in-flight response.

Parameters:
N, 64, PC/address width
INSTR_W, 32, instruction width
DEPTH, 4, instruction FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
EXC_VECTOR, 64'hD8, exception handler address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Exc_F  in  1  exception redirect request
ERet_F  in  1  exception-return redirect request
ERetAddr_F  in  N  ERET target (saved ELR)
PCSrc_F  in  1  branch redirect request
PCBranch_F  in  N  branch target
imem_req_F  out  1  fetch request valid
imem_addr_F  out  N  fetch address
imem_ready_F  in  1  memory accepts request this cycle
imem_rvalid_F  in  1  response valid
imem_rdata_F  in  INSTR_W  response instruction
valid_D  out  1  FIFO head valid
instr_D  out  INSTR_W  head instruction
pc_D  out  N  head PC
ready_D  in  1  decode consumes head

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, state RUN, FIFO empty (count=0), kill=0, imem_req_F=0, valid_D=0. instr_D and pc_D read as 0 while empty. Any response arriving after reset is ignored.
- States:
  - RUN: no request outstanding.
  - WAIT: one request outstanding, kill flag records a pending squash.
- RUN:
  - imem_req_F = (count < DEPTH) and no redirect this cycle; imem_addr_F = PC.
  - Address is held stable until accepted.
  - Accept (req && ready): inflight_pc <= PC, PC <= PC+4 (mod 2^N), go to WAIT with kill=0.
  - imem_rvalid_F is ignored in RUN.
- WAIT:
  - imem_req_F=0.
  - On rvalid: if kill=0, push {inflight_pc, rdata}; if kill=1, drop it. Go to RUN.
  - Response latency is >=1 cycle after acceptance.
- Redirect priority: Exc_F > ERet_F > PCSrc_F.
  - Target is EXC_VECTOR, ERetAddr_F or PCBranch_F respectively.
  - PC <= target, FIFO flushed (count=0), and a redirect cycle suppresses imem_req_F.
  - Target is driven on imem_addr_F from the next cycle.
- Redirect while in WAIT without rvalid: kill <= 1, stay in WAIT.
- Redirect while in WAIT with rvalid in the same cycle: response dropped, go to RUN.
- Flush beats pop: a pop in the redirect cycle is discarded.
- FIFO:
  - valid_D = (count != 0); instr_D and pc_D are the head entry (registered storage, no bypass).
  - Pop on valid_D && ready_D.
  - Push and pop in the same cycle leaves count unchanged.
  - Overflow is impossible by construction: issue requires count < DEPTH and only one request is outstanding. An assertion checks that no push occurs at count==DEPTH.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetched_cnt[31:0] and squashed_cnt[31:0], both reset to 0.
  - fetched_cnt increments on each FIFO push.
  - squashed_cnt increments per dropped response plus the FIFO count discarded at each flush.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, ready=1, rvalid 1 cycle after each accept, ready_D=1 -> addresses 0,4,8,…; pc_D/instr_D stream in order; first valid_D 2 cycles after the first accept.
- ready_D=0, DEPTH=4 -> after 4 pushes imem_req_F stays 0, count=4. Raise ready_D -> requests resume at PC=0x10.
- PCSrc_F=1, PCBranch_F=0x100 while in WAIT with 2 entries queued -> valid_D=0 next cycle; stale rvalid dropped; next imem_addr_F=0x100.
- Exc_F and PCSrc_F in the same cycle (ERetAddr_F=0x40, PCBranch_F=0x80) -> PC=EXC_VECTOR=0xD8. Next cycle ERet_F alone -> PC=0x40.
- imem_ready_F held low 3 cycles -> imem_addr_F stable, PC unchanged; accepted on cycle 4.
- Assert reset mid-WAIT with 3 queued entries -> all outputs reset immediately; later rvalid ignored; first post-reset request address 0.
